// File: rtl/lc3_golden_model.sv
// lc3_golden_model: cycle-driven LC-3 reference model. Mirrors PC, R0-R7 and NZP,
// watches fetched instructions and memory read data, and emits the expected
// address/data stream (plus error pulses) for the instruction checker.
module lc3_golden_model #(
  parameter logic [15:0] PC_RESET    = 16'h3000,
  parameter logic [2:0]  RESET_CC    = 3'b010,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_instr_valid,
  input  logic [15:0] i_instr,
  input  logic        i_mem_rvalid,
  input  logic [15:0] i_mem_rdata,
  output logic [15:0] o_addr_ideal,
  output logic [15:0] o_data_ideal,
  output logic        o_exp_valid,
  output logic [2:0]  o_exp_kind,
  output logic [15:0] o_pc_model,
  output logic [2:0]  o_cc_model,
  output logic        o_busy,
  output logic        o_err_illegal,
  output logic        o_err_overrun,
  output logic        o_err_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WAIT_PTR,
    S_WAIT_RD
  } state_t;

  localparam logic [2:0] KIND_ALU      = 3'd0;
  localparam logic [2:0] KIND_NEXT_PC  = 3'd1;
  localparam logic [2:0] KIND_LD_ADDR  = 3'd2;
  localparam logic [2:0] KIND_PTR_ADDR = 3'd3;
  localparam logic [2:0] KIND_ST       = 3'd4;
  localparam logic [2:0] KIND_LD_WB    = 3'd5;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

  // Condition codes derived from a 16-bit value; exactly one bit is ever set.
  function automatic logic [2:0] calc_nzp(input logic [15:0] value);
    if (value[15])            return 3'b100;
    else if (value == 16'h0)  return 3'b010;
    else                      return 3'b001;
  endfunction

  state_t      r_state;
  logic [15:0] r_ir;
  logic [15:0] r_pc;
  logic [2:0]  r_cc;
  logic [15:0] r_regs [0:7];
  logic [15:0] r_tcnt;
  logic [15:0] r_addr;
  logic [15:0] r_data;
  logic [2:0]  r_kind;
  logic        r_exp_valid;
  logic        r_err_illegal;
  logic        r_err_overrun;
  logic        r_err_timeout;

  state_t      w_state_nxt;
  logic [15:0] w_ir_nxt;
  logic [15:0] w_pc_nxt;
  logic [2:0]  w_cc_nxt;
  logic [15:0] w_tcnt_nxt;
  logic [15:0] w_addr_nxt;
  logic [15:0] w_data_nxt;
  logic [2:0]  w_kind_nxt;
  logic        w_exp_valid_nxt;
  logic        w_err_illegal_nxt;
  logic        w_err_overrun_nxt;
  logic        w_err_timeout_nxt;
  logic        w_we;
  logic [2:0]  w_wa;
  logic [15:0] w_wd;
  logic        w_is_alu;
  logic [15:0] w_res;

  logic [3:0]  w_op;
  logic [2:0]  w_dr;
  logic [2:0]  w_sr1;
  logic [2:0]  w_sr2;
  logic [15:0] w_off5;
  logic [15:0] w_off6;
  logic [15:0] w_off9;
  logic [15:0] w_off11;
  logic [15:0] w_rs1;
  logic [15:0] w_rs2;
  logic [15:0] w_rdr;
  logic [15:0] w_pc_off9;
  logic [15:0] w_base_off6;
  logic        w_br_taken;
  logic [15:0] w_jsr_target;

  // Field decode of the latched instruction; PC here is already incremented.
  assign w_op         = r_ir[15:12];
  assign w_dr         = r_ir[11:9];
  assign w_sr1        = r_ir[8:6];
  assign w_sr2        = r_ir[2:0];
  assign w_off5       = {{11{r_ir[4]}}, r_ir[4:0]};
  assign w_off6       = {{10{r_ir[5]}}, r_ir[5:0]};
  assign w_off9       = {{7{r_ir[8]}}, r_ir[8:0]};
  assign w_off11      = {{5{r_ir[10]}}, r_ir[10:0]};
  assign w_rs1        = r_regs[w_sr1];
  assign w_rs2        = r_regs[w_sr2];
  assign w_rdr        = r_regs[w_dr];
  assign w_pc_off9    = r_pc + w_off9;
  assign w_base_off6  = w_rs1 + w_off6;
  assign w_br_taken   = (r_ir[11] & r_cc[2]) | (r_ir[10] & r_cc[1]) | (r_ir[9] & r_cc[0]);
  assign w_jsr_target = r_ir[11] ? (r_pc + w_off11) : w_rs1;

  assign o_addr_ideal  = r_addr;
  assign o_data_ideal  = r_data;
  assign o_exp_valid   = r_exp_valid;
  assign o_exp_kind    = r_kind;
  assign o_pc_model    = r_pc;
  assign o_cc_model    = r_cc;
  assign o_busy        = (r_state != S_IDLE);
  assign o_err_illegal = r_err_illegal;
  assign o_err_overrun = r_err_overrun;
  assign o_err_timeout = r_err_timeout;

  // Next-state and next-value logic for the whole model; pulses default low, the rest hold.
  always_comb begin
    w_state_nxt       = r_state;
    w_ir_nxt          = r_ir;
    w_pc_nxt          = r_pc;
    w_cc_nxt          = r_cc;
    w_tcnt_nxt        = r_tcnt;
    w_addr_nxt        = r_addr;
    w_data_nxt        = r_data;
    w_kind_nxt        = r_kind;
    w_exp_valid_nxt   = 1'b0;
    w_err_illegal_nxt = 1'b0;
    w_err_overrun_nxt = 1'b0;
    w_err_timeout_nxt = 1'b0;
    w_we              = 1'b0;
    w_wa              = 3'd0;
    w_wd              = 16'h0;
    w_is_alu          = 1'b0;
    w_res             = 16'h0;

    if (i_instr_valid && (r_state != S_IDLE)) begin
      w_err_overrun_nxt = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (i_instr_valid) begin
          w_ir_nxt    = i_instr;
          w_pc_nxt    = r_pc + 16'd1;
          w_state_nxt = S_EXEC;
        end
      end

      S_EXEC: begin
        w_state_nxt = S_IDLE;
        w_tcnt_nxt  = 16'h0;
        case (w_op)
          OP_ADD: begin
            w_is_alu = 1'b1;
            w_res    = w_rs1 + (r_ir[5] ? w_off5 : w_rs2);
          end
          OP_AND: begin
            w_is_alu = 1'b1;
            w_res    = w_rs1 & (r_ir[5] ? w_off5 : w_rs2);
          end
          OP_NOT: begin
            w_is_alu = 1'b1;
            w_res    = ~w_rs1;
          end
          OP_LEA: begin
            w_is_alu = 1'b1;
            w_res    = w_pc_off9;
          end
          OP_BR: begin
            w_pc_nxt        = w_br_taken ? w_pc_off9 : r_pc;
            w_addr_nxt      = w_br_taken ? w_pc_off9 : r_pc;
            w_kind_nxt      = KIND_NEXT_PC;
            w_exp_valid_nxt = 1'b1;
          end
          OP_JMP: begin
            w_pc_nxt        = w_rs1;
            w_addr_nxt      = w_rs1;
            w_kind_nxt      = KIND_NEXT_PC;
            w_exp_valid_nxt = 1'b1;
          end
          OP_JSR: begin
            w_we            = 1'b1;
            w_wa            = 3'd7;
            w_wd            = r_pc;
            w_pc_nxt        = w_jsr_target;
            w_addr_nxt      = w_jsr_target;
            w_kind_nxt      = KIND_NEXT_PC;
            w_exp_valid_nxt = 1'b1;
          end
          OP_LD, OP_LDR: begin
            w_addr_nxt      = (w_op == OP_LD) ? w_pc_off9 : w_base_off6;
            w_kind_nxt      = KIND_LD_ADDR;
            w_exp_valid_nxt = 1'b1;
            w_state_nxt     = S_WAIT_RD;
          end
          OP_LDI, OP_STI: begin
            w_addr_nxt      = w_pc_off9;
            w_kind_nxt      = KIND_LD_ADDR;
            w_exp_valid_nxt = 1'b1;
            w_state_nxt     = S_WAIT_PTR;
          end
          OP_ST, OP_STR: begin
            w_addr_nxt      = (w_op == OP_ST) ? w_pc_off9 : w_base_off6;
            w_data_nxt      = w_rdr;
            w_kind_nxt      = KIND_ST;
            w_exp_valid_nxt = 1'b1;
          end
          default: begin
            w_err_illegal_nxt = 1'b1;
          end
        endcase
        if (w_is_alu) begin
          w_we            = 1'b1;
          w_wa            = w_dr;
          w_wd            = w_res;
          w_cc_nxt        = calc_nzp(w_res);
          w_data_nxt      = w_res;
          w_kind_nxt      = KIND_ALU;
          w_exp_valid_nxt = 1'b1;
        end
      end

      S_WAIT_PTR: begin
        if (i_mem_rvalid) begin
          w_addr_nxt      = i_mem_rdata;
          w_exp_valid_nxt = 1'b1;
          if (w_op == OP_STI) begin
            w_data_nxt  = w_rdr;
            w_kind_nxt  = KIND_ST;
            w_state_nxt = S_IDLE;
          end else begin
            w_kind_nxt  = KIND_PTR_ADDR;
            w_state_nxt = S_WAIT_RD;
            w_tcnt_nxt  = 16'h0;
          end
        end else if (r_tcnt == TIMEOUT_LAST) begin
          w_err_timeout_nxt = 1'b1;
          w_state_nxt       = S_IDLE;
        end else begin
          w_tcnt_nxt = r_tcnt + 16'd1;
        end
      end

      S_WAIT_RD: begin
        if (i_mem_rvalid) begin
          w_we            = 1'b1;
          w_wa            = w_dr;
          w_wd            = i_mem_rdata;
          w_cc_nxt        = calc_nzp(i_mem_rdata);
          w_data_nxt      = i_mem_rdata;
          w_kind_nxt      = KIND_LD_WB;
          w_exp_valid_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end else if (r_tcnt == TIMEOUT_LAST) begin
          w_err_timeout_nxt = 1'b1;
          w_state_nxt       = S_IDLE;
        end else begin
          w_tcnt_nxt = r_tcnt + 16'd1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register; reset aborts any instruction in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Architectural state (PC, NZP, IR), wait counter and registered expectation outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ir          <= 16'h0;
      r_pc          <= PC_RESET;
      r_cc          <= RESET_CC;
      r_tcnt        <= 16'h0;
      r_addr        <= 16'h0;
      r_data        <= 16'h0;
      r_kind        <= 3'd0;
      r_exp_valid   <= 1'b0;
      r_err_illegal <= 1'b0;
      r_err_overrun <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_ir          <= w_ir_nxt;
      r_pc          <= w_pc_nxt;
      r_cc          <= w_cc_nxt;
      r_tcnt        <= w_tcnt_nxt;
      r_addr        <= w_addr_nxt;
      r_data        <= w_data_nxt;
      r_kind        <= w_kind_nxt;
      r_exp_valid   <= w_exp_valid_nxt;
      r_err_illegal <= w_err_illegal_nxt;
      r_err_overrun <= w_err_overrun_nxt;
      r_err_timeout <= w_err_timeout_nxt;
    end
  end

  // Register file R0-R7 with a single write port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= 16'h0;
      end
    end else if (w_we) begin
      r_regs[w_wa] <= w_wd;
    end
  end

endmodule

// File: tb/tb_lc3_golden_model.sv
// tb_lc3_golden_model: directed LC-3 program against the golden model. Expected events
// are queued when each instruction is issued; a monitor pops and compares them whenever
// the model pulses exp_valid or an error flag.
module tb_lc3_golden_model;

  localparam int MEM_TIMEOUT = 16;

  localparam int EV_EXP = 0;
  localparam int EV_ILL = 1;
  localparam int EV_OVR = 2;
  localparam int EV_TMO = 3;

  localparam logic [2:0] K_ALU  = 3'd0;
  localparam logic [2:0] K_NPC  = 3'd1;
  localparam logic [2:0] K_LDA  = 3'd2;
  localparam logic [2:0] K_PTR  = 3'd3;
  localparam logic [2:0] K_ST   = 3'd4;
  localparam logic [2:0] K_LDWB = 3'd5;

  typedef struct {
    int          evType;
    logic [2:0]  kind;
    logic [15:0] addr;
    logic [15:0] data;
    bit          chkAddr;
    bit          chkData;
    string       tag;
  } expect_t;

  logic        clock;
  logic        resetN;
  logic        instrValid;
  logic [15:0] instr;
  logic        memRvalid;
  logic [15:0] memRdata;
  logic [15:0] addrIdeal;
  logic [15:0] dataIdeal;
  logic        expValid;
  logic [2:0]  expKind;
  logic [15:0] pcModel;
  logic [2:0]  ccModel;
  logic        busy;
  logic        errIllegal;
  logic        errOverrun;
  logic        errTimeout;

  expect_t sbQueue[$];
  int      testsRun    = 0;
  int      testsFailed = 0;

  lc3_golden_model #(
    .PC_RESET   (16'h3000),
    .RESET_CC   (3'b010),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .i_clk        (clock),
    .i_rst_n      (resetN),
    .i_instr_valid(instrValid),
    .i_instr      (instr),
    .i_mem_rvalid (memRvalid),
    .i_mem_rdata  (memRdata),
    .o_addr_ideal (addrIdeal),
    .o_data_ideal (dataIdeal),
    .o_exp_valid  (expValid),
    .o_exp_kind   (expKind),
    .o_pc_model   (pcModel),
    .o_cc_model   (ccModel),
    .o_busy       (busy),
    .o_err_illegal(errIllegal),
    .o_err_overrun(errOverrun),
    .o_err_timeout(errTimeout)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case the program sequence itself gets stuck.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input string tag, input logic [2:0] kind, input logic [15:0] addr,
                         input logic [15:0] data, input bit chkAddr, input bit chkData);
    expect_t e;
    e.evType  = EV_EXP;
    e.kind    = kind;
    e.addr    = addr;
    e.data    = data;
    e.chkAddr = chkAddr;
    e.chkData = chkData;
    e.tag     = tag;
    sbQueue.push_back(e);
  endtask

  task automatic pushErr(input string tag, input int evType);
    expect_t e;
    e.evType  = evType;
    e.kind    = 3'd0;
    e.addr    = 16'h0;
    e.data    = 16'h0;
    e.chkAddr = 1'b0;
    e.chkData = 1'b0;
    e.tag     = tag;
    sbQueue.push_back(e);
  endtask

  task automatic checkEvent(input int evType);
    expect_t e;
    if (sbQueue.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL unexpectedEvent: got event type %0d, required no event", evType);
    end else begin
      e = sbQueue.pop_front();
      checkOutput({e.tag, ".type"}, 16'(evType), 16'(e.evType));
      if (evType == EV_EXP && e.evType == EV_EXP) begin
        checkOutput({e.tag, ".kind"}, {13'b0, expKind}, {13'b0, e.kind});
        if (e.chkAddr) checkOutput({e.tag, ".addr"}, addrIdeal, e.addr);
        if (e.chkData) checkOutput({e.tag, ".data"}, dataIdeal, e.data);
      end
    end
  endtask

  // Monitor: on the falling edge, consume one expectation per asserted output pulse.
  always @(negedge clock) begin
    if (expValid)   checkEvent(EV_EXP);
    if (errIllegal) checkEvent(EV_ILL);
    if (errOverrun) checkEvent(EV_OVR);
    if (errTimeout) checkEvent(EV_TMO);
  end

  // One-cycle instr_valid pulse; returns just after the EXEC edge.
  task automatic applyStimulus(input logic [15:0] word);
    @(posedge clock); #1;
    instr      = word;
    instrValid = 1'b1;
    @(posedge clock); #1;
    instrValid = 1'b0;
    @(posedge clock); #1;
  endtask

  // One-cycle mem_rvalid pulse carrying read data.
  task automatic applyRead(input logic [15:0] value);
    memRvalid = 1'b1;
    memRdata  = value;
    @(posedge clock); #1;
    memRvalid = 1'b0;
  endtask

  // Bounded wait for the model to return to IDLE.
  task automatic waitIdle(input string name);
    int cycles;
    cycles = 0;
    while (busy && cycles < 40) begin
      @(posedge clock); #1;
      cycles++;
    end
    checkOutput({name, ".idle"}, {15'b0, busy}, 16'h0);
  endtask

  initial begin
    int waitCycles;
    instrValid = 1'b0;
    instr      = 16'h0;
    memRvalid  = 1'b0;
    memRdata   = 16'h0;
    resetN     = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset.pc",   pcModel, 16'h3000);
    checkOutput("reset.cc",   {13'b0, ccModel}, 16'h0002);
    checkOutput("reset.busy", {15'b0, busy}, 16'h0);
    checkOutput("reset.addr", addrIdeal, 16'h0);
    checkOutput("reset.data", dataIdeal, 16'h0);
    checkOutput("reset.expv", {15'b0, expValid}, 16'h0);
    resetN = 1'b1;

    // ADD R1,R1,#-1 with R1=0 at x3000
    pushExp("addNeg", K_ALU, 16'h0, 16'hFFFF, 1'b0, 1'b1);
    applyStimulus(16'h127F);
    checkOutput("addNeg.pc", pcModel, 16'h3001);
    checkOutput("addNeg.cc", {13'b0, ccModel}, 16'h0004);

    // BRz #-2 with N set: falls through
    pushExp("brzNotTaken", K_NPC, 16'h3002, 16'h0, 1'b1, 1'b0);
    applyStimulus(16'h05FE);
    // AND R1,R1,#0 -> Z
    pushExp("andZero", K_ALU, 16'h0, 16'h0000, 1'b0, 1'b1);
    applyStimulus(16'h5260);
    checkOutput("andZero.cc", {13'b0, ccModel}, 16'h0002);
    // BRz #-2 at x3003 with Z set: taken to x3002
    pushExp("brzTaken", K_NPC, 16'h3002, 16'h0, 1'b1, 1'b0);
    applyStimulus(16'h05FE);
    checkOutput("brzTaken.pc", pcModel, 16'h3002);
    // BR with nzp=000 never taken
    pushExp("brNever", K_NPC, 16'h3003, 16'h0, 1'b1, 1'b0);
    applyStimulus(16'h01FF);

    // ADD R2,R2,#5 then LDI R2,#4 through pointer xABCD returning x0000
    pushExp("addImm", K_ALU, 16'h0, 16'h0005, 1'b0, 1'b1);
    applyStimulus(16'h14A5);
    pushExp("ldi.addr", K_LDA, 16'h3009, 16'h0, 1'b1, 1'b0);
    pushExp("ldi.ptr", K_PTR, 16'hABCD, 16'h0, 1'b1, 1'b0);
    pushExp("ldi.wb", K_LDWB, 16'h0, 16'h0000, 1'b0, 1'b1);
    applyStimulus(16'hA404);
    applyRead(16'hABCD);
    applyRead(16'h0000);
    waitIdle("ldi");
    checkOutput("ldi.cc", {13'b0, ccModel}, 16'h0002);
    checkOutput("ldi.pc", pcModel, 16'h3005);
    // ST R2 shows R2 was written with zero
    pushExp("stR2", K_ST, 16'h3006, 16'h0000, 1'b1, 1'b1);
    applyStimulus(16'h3400);

    // Stray read data while idle must produce nothing
    @(posedge clock); #1;
    applyRead(16'hDEAD);

    // Build R6 = x0010
    pushExp("andR6", K_ALU, 16'h0, 16'h0000, 1'b0, 1'b1);
    applyStimulus(16'h5DA0);
    pushExp("addR6a", K_ALU, 16'h0, 16'h000F, 1'b0, 1'b1);
    applyStimulus(16'h1DAF);
    pushExp("addR6b", K_ALU, 16'h0, 16'h0010, 1'b0, 1'b1);
    applyStimulus(16'h1DA1);

    // LD R3,#-1 loads x1234
    pushExp("ldR3.addr", K_LDA, 16'h3009, 16'h0, 1'b1, 1'b0);
    pushExp("ldR3.wb", K_LDWB, 16'h0, 16'h1234, 1'b0, 1'b1);
    applyStimulus(16'h27FF);
    applyRead(16'h1234);
    waitIdle("ldR3");
    checkOutput("ldR3.cc", {13'b0, ccModel}, 16'h0001);

    // STR R3,R6,#-32 wraps to xFFF0
    pushExp("strWrap", K_ST, 16'hFFF0, 16'h1234, 1'b1, 1'b1);
    applyStimulus(16'h77A0);
    // NOT, ADD reg, AND reg, LEA
    pushExp("notR4", K_ALU, 16'h0, 16'hEDCB, 1'b0, 1'b1);
    applyStimulus(16'h98FF);
    checkOutput("notR4.cc", {13'b0, ccModel}, 16'h0004);
    pushExp("addReg", K_ALU, 16'h0, 16'hFFFF, 1'b0, 1'b1);
    applyStimulus(16'h1AC4);
    pushExp("andReg", K_ALU, 16'h0, 16'h0000, 1'b0, 1'b1);
    applyStimulus(16'h5AC4);
    pushExp("leaNeg", K_ALU, 16'h0, 16'h2F0F, 1'b0, 1'b1);
    applyStimulus(16'hE100);
    checkOutput("leaNeg.cc", {13'b0, ccModel}, 16'h0001);

    // LD R7 = x4000, JSRR R7 uses the old R7
    pushExp("ldR7.addr", K_LDA, 16'h3010, 16'h0, 1'b1, 1'b0);
    pushExp("ldR7.wb", K_LDWB, 16'h0, 16'h4000, 1'b0, 1'b1);
    applyStimulus(16'h2E00);
    applyRead(16'h4000);
    waitIdle("ldR7");
    pushExp("jsrrR7", K_NPC, 16'h4000, 16'h0, 1'b1, 1'b0);
    applyStimulus(16'h41C0);
    checkOutput("jsrrR7.pc", pcModel, 16'h4000);
    pushExp("stR7link", K_ST, 16'h4001, 16'h3011, 1'b1, 1'b1);
    applyStimulus(16'h3E00);
    // JSR #-1, then JMP R6
    pushExp("jsrRel", K_NPC, 16'h4001, 16'h0, 1'b1, 1'b0);
    applyStimulus(16'h4FFF);
    pushExp("jmpR6", K_NPC, 16'h0010, 16'h0, 1'b1, 1'b0);
    applyStimulus(16'hC180);

    // RTI, TRAP, reserved: illegal, PC still advances
    pushErr("illRti", EV_ILL);
    applyStimulus(16'h8000);
    pushErr("illTrap", EV_ILL);
    applyStimulus(16'hF025);
    pushErr("illRsv", EV_ILL);
    applyStimulus(16'hD000);
    checkOutput("illegal.pc", pcModel, 16'h0013);

    // STI R3,#2 through pointer xBEEF: single ST pulse
    pushExp("sti.addr", K_LDA, 16'h0016, 16'h0, 1'b1, 1'b0);
    pushExp("sti.st", K_ST, 16'hBEEF, 16'h1234, 1'b1, 1'b1);
    applyStimulus(16'hB602);
    applyRead(16'hBEEF);
    waitIdle("sti");

    // LD R1 with an overrunning fetch while waiting
    pushExp("ldOvr.addr", K_LDA, 16'h0015, 16'h0, 1'b1, 1'b0);
    pushErr("overrun", EV_OVR);
    pushExp("ldOvr.wb", K_LDWB, 16'h0, 16'h8000, 1'b0, 1'b1);
    applyStimulus(16'h2200);
    applyStimulus(16'h127F);
    applyRead(16'h8000);
    waitIdle("ldOvr");
    checkOutput("ldOvr.pc", pcModel, 16'h0015);
    checkOutput("ldOvr.cc", {13'b0, ccModel}, 16'h0004);

    // LD R1 with no read data: timeout, no register write
    pushExp("ldTmo.addr", K_LDA, 16'h0016, 16'h0, 1'b1, 1'b0);
    pushErr("timeout", EV_TMO);
    applyStimulus(16'h2200);
    waitCycles = 0;
    while (!errTimeout && waitCycles < 40) begin
      @(posedge clock); #1;
      waitCycles++;
    end
    checkOutput("timeout.cycles", 16'(waitCycles), 16'(MEM_TIMEOUT));
    checkOutput("timeout.busy", {15'b0, busy}, 16'h0);
    pushExp("stR1", K_ST, 16'h0017, 16'h8000, 1'b1, 1'b1);
    applyStimulus(16'h3200);
    pushExp("stR7jsr", K_ST, 16'h0018, 16'h4002, 1'b1, 1'b1);
    applyStimulus(16'h3E00);

    // Reset in the middle of WAIT_RD
    pushExp("ldRst.addr", K_LDA, 16'h0019, 16'h0, 1'b1, 1'b0);
    applyStimulus(16'h2000);
    @(posedge clock); #1;
    resetN = 1'b0;
    #1;
    checkOutput("midReset.pc", pcModel, 16'h3000);
    checkOutput("midReset.busy", {15'b0, busy}, 16'h0);
    checkOutput("midReset.cc", {13'b0, ccModel}, 16'h0002);
    @(posedge clock); #1;
    resetN = 1'b1;
    pushExp("stAfterRst", K_ST, 16'h3001, 16'h0000, 1'b1, 1'b1);
    applyStimulus(16'h3200);

    repeat (3) @(posedge clock);
    #1;
    checkOutput("scoreboardEmpty", 16'(sbQueue.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
